// File: rtl/m_conv_mac_2.sv
// m_conv_mac_2 -- layer-2 convolution multiply-accumulate stage.
//
// Takes the serial tap stream of the window-ordered input buffer (KERNEL_N
// taps per output point). For each tap it addresses the kernel ROM and
// multiplies the tap by the returned weight. The products are accumulated.
// On the last tap of a window it adds the bias, rescales, applies ReLU and
// saturates. The result is written out with a one-cycle strobe.
//
// Ports
//   clk_in    : clock, rising edge
//   rst_n     : synchronous active-low reset
//   map_in    : signed pixel tap
//   valid_in  : map_in valid this cycle
//   k_loop    : upstream loop-boundary pulse (window resync check)
//   w_addr    : kernel ROM address, loop_cnt*KERNEL_N + tap
//   weight    : signed ROM data, one cycle after w_addr
//   bias      : signed bias of the current loop, sampled at the output stage
//   map_out   : result, 0..32767, held between strobes
//   wr        : one-cycle strobe for map_out
//   done      : sticky, last output of the last loop has been written
//   err       : sticky, k_loop arrived in the middle of a window
module m_conv_mac_2 #(
    parameter int KERNEL_N  = 25,
    parameter int FRAC_BITS = 8,
    parameter int NUM_OUT   = 324,
    parameter int NUM_LOOP  = 4
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic signed [15:0] map_in,
    input  logic               valid_in,
    input  logic               k_loop,
    output logic [6:0]         w_addr,
    input  logic signed [15:0] weight,
    input  logic signed [15:0] bias,
    output logic signed [15:0] map_out,
    output logic               wr,
    output logic               done,
    output logic               err
);

    localparam int TW = (KERNEL_N > 1) ? $clog2(KERNEL_N) : 1;
    localparam int OW = (NUM_OUT  > 1) ? $clog2(NUM_OUT)  : 1;
    localparam int LW = (NUM_LOOP > 1) ? $clog2(NUM_LOOP) : 1;

    logic [TW-1:0] tap_cnt, tap_eff;
    logic [OW-1:0] out_cnt;
    logic [LW-1:0] loop_cnt;
    logic          halt;
    logic          accept, is_last, out_wrap, loop_wrap;

    logic signed [15:0] p1;
    logic               v1, first1, last1, fin1;
    logic signed [31:0] prod;
    logic               v2, first2, last2, fin2;
    logic signed [39:0] acc;
    logic               v3, fin3;
    logic signed [39:0] sum, r;
    logic signed [15:0] sat;

    // k_loop takes effect before a tap presented in the same cycle, so that
    // tap is addressed and tagged as tap 0.
    always_comb begin
        tap_eff   = k_loop ? '0 : tap_cnt;
        accept    = valid_in && !halt;
        is_last   = (tap_eff == TW'(KERNEL_N - 1));
        out_wrap  = (out_cnt == OW'(NUM_OUT - 1));
        loop_wrap = (loop_cnt == LW'(NUM_LOOP - 1));
        w_addr    = 7'(loop_cnt) * 7'(KERNEL_N) + 7'(tap_eff);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            tap_cnt  <= '0;
            out_cnt  <= '0;
            loop_cnt <= '0;
            halt     <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (k_loop && (tap_cnt != '0))
                err <= 1'b1;
            if (accept) begin
                if (is_last) begin
                    tap_cnt <= '0;
                    if (out_wrap) begin
                        out_cnt <= '0;
                        if (loop_wrap) begin
                            loop_cnt <= '0;
                            halt     <= 1'b1;
                        end else begin
                            loop_cnt <= loop_cnt + LW'(1);
                        end
                    end else begin
                        out_cnt <= out_cnt + OW'(1);
                    end
                end else begin
                    tap_cnt <= tap_eff + TW'(1);
                end
            end else if (k_loop) begin
                tap_cnt <= '0;
            end
        end
    end

    // Bias, rescale, ReLU and saturation on the finished accumulator.
    always_comb begin
        sum = acc + (40'(bias) <<< FRAC_BITS);
        r   = sum >>> FRAC_BITS;
        if (r[39])
            sat = 16'sd0;
        else if (r > 40'sd32767)
            sat = 16'sd32767;
        else
            sat = r[15:0];
    end

    // A window abandoned by k_loop never carries a last flag, and the next
    // window's first tap overwrites the accumulator, so its partial sum is
    // dropped without extra logic.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            p1 <= '0; v1 <= 1'b0; first1 <= 1'b0; last1 <= 1'b0; fin1 <= 1'b0;
            prod <= '0; v2 <= 1'b0; first2 <= 1'b0; last2 <= 1'b0; fin2 <= 1'b0;
            acc <= '0; v3 <= 1'b0; fin3 <= 1'b0;
            map_out <= '0;
            wr      <= 1'b0;
            done    <= 1'b0;
        end else begin
            p1     <= map_in;
            v1     <= accept;
            first1 <= accept && (tap_eff == '0);
            last1  <= accept && is_last;
            fin1   <= accept && is_last && out_wrap && loop_wrap;

            prod   <= p1 * weight;
            v2     <= v1;
            first2 <= first1;
            last2  <= last1;
            fin2   <= fin1;

            if (v2)
                acc <= first2 ? 40'(prod) : acc + 40'(prod);
            v3   <= v2 && last2;
            fin3 <= v2 && fin2;

            wr <= v3;
            if (v3)
                map_out <= sat;
            if (fin3)
                done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_m_conv_mac_2.sv
// tb_m_conv_mac_2 -- directed bench for m_conv_mac_2.
//
// Runs the DUT with NUM_OUT=2, NUM_LOOP=2 so one reset-to-done pass covers
// four outputs. A synchronous ROM model returns rom[w_addr] one cycle later.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the falling edge.
module tb_m_conv_mac_2;

    localparam int KN = 25;

    logic               clk_in = 1'b0;
    logic               rst_n;
    logic signed [15:0] map_in;
    logic               valid_in;
    logic               k_loop;
    logic [6:0]         w_addr;
    logic signed [15:0] weight;
    logic signed [15:0] bias;
    logic signed [15:0] map_out;
    logic               wr;
    logic               done;
    logic               err;

    logic signed [15:0] rom [0:127];
    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;

    m_conv_mac_2 #(
        .KERNEL_N(KN), .FRAC_BITS(8), .NUM_OUT(2), .NUM_LOOP(2)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .map_in(map_in), .valid_in(valid_in),
        .k_loop(k_loop), .w_addr(w_addr), .weight(weight), .bias(bias),
        .map_out(map_out), .wr(wr), .done(done), .err(err)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) weight <= rom[w_addr];

    always @(negedge clk_in) if (wr === 1'b1) wr_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic fill_rom(input int base, input logic signed [15:0] w);
        for (int i = 0; i < KN; i++) rom[base + i] = w;
    endtask

    // Drive one full window, checking the ROM address on every cycle. Then
    // check that wr rises only in the 4th cycle after the last tap and that
    // map_out holds afterwards.
    task automatic window(input logic signed [15:0] d, input int base, input bit gap,
                          input bit kl_first, input int exp_out, input string tag);
        for (int i = 0; i < KN; i++) begin
            if (gap && i > 0) begin
                @(negedge clk_in);
                valid_in = 1'b0;
                map_in   = 16'sd0;
                #1 chk({tag, " idle addr"}, 32'(w_addr), base + i);
            end
            @(negedge clk_in);
            valid_in = 1'b1;
            map_in   = d;
            k_loop   = kl_first && (i == 0);
            #1 chk({tag, " addr"}, 32'(w_addr), base + i);
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_in);
            valid_in = 1'b0;
            k_loop   = 1'b0;
            #1 chk({tag, " wr early"}, 32'(wr), 0);
        end
        @(negedge clk_in);
        #1;
        chk({tag, " wr"}, 32'(wr), 1);
        chk({tag, " map_out"}, 32'(map_out), exp_out);
        @(negedge clk_in);
        #1;
        chk({tag, " wr pulse"}, 32'(wr), 0);
        chk({tag, " hold"}, 32'(map_out), exp_out);
    endtask

    initial begin
        int n0;
        rst_n = 1'b0; valid_in = 1'b0; k_loop = 1'b0; map_in = '0; bias = '0;
        for (int i = 0; i < 128; i++) rom[i] = 16'sd256;
        repeat (3) @(negedge clk_in);
        #1;
        chk("rst map_out", 32'(map_out), 0);
        chk("rst wr", 32'(wr), 0);
        chk("rst done", 32'(done), 0);
        chk("rst err", 32'(err), 0);
        chk("rst w_addr", 32'(w_addr), 0);
        rst_n = 1'b1;

        // k_loop on a window boundary is harmless.
        @(negedge clk_in); k_loop = 1'b1;
        @(negedge clk_in); k_loop = 1'b0;
        #1 chk("kloop at tap0 err", 32'(err), 0);

        // 25 * 256*256 + (256<<8) = 1703936, >>8 = 6656
        bias = 16'sd256;
        window(16'sd256, 0, 1'b0, 1'b0, 6656, "basic");
        chk("basic wr count", wr_cnt, 1);

        // 10 taps, then a k_loop arrives with the next window's first tap.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in); valid_in = 1'b1; map_in = 16'sd256;
        end
        window(16'sd256, 0, 1'b0, 1'b1, 6656, "kloop");
        chk("kloop err", 32'(err), 1);
        chk("kloop wr count", wr_cnt, 2);
        chk("kloop done", 32'(done), 0);

        // Second loop: ROM base 25. -1638400 >> 8 = -6400 -> ReLU 0
        fill_rom(25, -16'sd256);
        bias = 16'sd0;
        window(16'sd256, 25, 1'b0, 1'b0, 0, "relu");
        chk("relu done", 32'(done), 0);

        fill_rom(25, 16'sd32767);
        bias = 16'sd32767;
        window(16'sd32767, 25, 1'b0, 1'b0, 32767, "sat");
        chk("done set", 32'(done), 1);
        chk("total wr count", wr_cnt, 4);

        // Once done, taps are ignored.
        n0 = wr_cnt;
        for (int i = 0; i < KN; i++) begin
            @(negedge clk_in); valid_in = 1'b1; map_in = 16'sd256;
        end
        @(negedge clk_in); valid_in = 1'b0;
        repeat (10) @(negedge clk_in);
        chk("no wr after done", wr_cnt, n0);
        chk("done sticky", 32'(done), 1);

        @(negedge clk_in); rst_n = 1'b0;
        @(negedge clk_in); rst_n = 1'b1;
        #1;
        chk("rst clears done", 32'(done), 0);
        chk("rst clears err", 32'(err), 0);
        chk("rst wr", 32'(wr), 0);

        fill_rom(0, 16'sd256);
        bias = 16'sd256;
        window(16'sd256, 0, 1'b1, 1'b0, 6656, "gap");
        chk("gap wr count", wr_cnt, n0 + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
